// File: rtl/eae_pkg.sv
// Shared definitions for the EAE divide sequencer.
//   WORD_W          machine word width (AC, MQ, divisor)
//   DIV_LATENCY     cycles from accept to div_finished on a normal divide
//   div_seq_state_t sequencer FSM states
//   div_overflow    unsigned AC >= divisor screen (covers divisor 0)
package eae_pkg;

    localparam int WORD_W      = 12;
    localparam int DIV_LATENCY = 14;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } div_seq_state_t;

    // The quotient only fits in one word when AC < divisor.
    function automatic logic div_overflow(input logic [WORD_W-1:0] ac,
                                          input logic [WORD_W-1:0] divisor);
        return ac >= divisor;
    endfunction

endpackage

// File: rtl/eae_div_sequencer.sv
// Sequences the EAE DVI instruction onto the shared 12-bit restoring divider.
// Ports:
//   clock, reset_n            system clock, asynchronous active-low reset
//   req                       divide request (AC:MQ / divisor)
//   ac_in, mq_in, divisor_in  operands, sampled on accept
//   busy                      high from accept through DONE and during FLUSH
//   done                      one-cycle pulse, results valid and held until next accept
//   ac_out, mq_out            remainder / quotient, or unchanged AC/MQ on failure
//   link_out                  0 on success, 1 on overflow or timeout
//   timeout_err               set with done when the divider never finished
//   div_dividend, div_divisor operands to the divider, latched on accept
//   div_start                 one-cycle divider start strobe
//   div_quotient, div_remainder, div_finished   divider results
//   fsm_state                 current sequencer state, for observation
//
// Handshake: req is taken (accepted) only in a cycle where busy is 0; a
// request while busy is high is ignored, and a request held high through
// DONE is accepted on the following idle cycle.
module eae_div_sequencer
    import eae_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int FLUSH_CYCLES   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic [WORD_W-1:0]     ac_in,
    input  logic [WORD_W-1:0]     mq_in,
    input  logic [WORD_W-1:0]     divisor_in,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_W-1:0]     ac_out,
    output logic [WORD_W-1:0]     mq_out,
    output logic                  link_out,
    output logic                  timeout_err,
    output logic [2*WORD_W-1:0]   div_dividend,
    output logic [WORD_W-1:0]     div_divisor,
    output logic                  div_start,
    input  logic [WORD_W-1:0]     div_quotient,
    input  logic [WORD_W-1:0]     div_remainder,
    input  logic                  div_finished,
    output div_seq_state_t        fsm_state
);

    // One counter serves both FLUSH and WAIT, so size it for the longer.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST   = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    div_seq_state_t   state;
    logic [CNT_W-1:0] cnt;

    assign fsm_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FLUSH;
            cnt          <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            ac_out       <= '0;
            mq_out       <= '0;
            link_out     <= 1'b0;
            timeout_err  <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_start    <= 1'b0;
        end else begin
            done      <= 1'b0;
            div_start <= 1'b0;
            case (state)
                // The divider has no reset; holding start low lets it fall back to S0.
                FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (req) begin
                        busy         <= 1'b1;
                        timeout_err  <= 1'b0;
                        div_dividend <= {ac_in, mq_in};
                        div_divisor  <= divisor_in;
                        cnt          <= '0;
                        if (div_overflow(ac_in, divisor_in)) begin
                            ac_out   <= ac_in;
                            mq_out   <= mq_in;
                            link_out <= 1'b1;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            div_start <= 1'b1;
                            state     <= LAUNCH;
                        end
                    end
                end
                // div_start drops by default here, so the strobe is exactly one cycle.
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (div_finished) begin
                        mq_out   <= div_quotient;
                        ac_out   <= div_remainder;
                        link_out <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        ac_out      <= div_dividend[2*WORD_W-1:WORD_W];
                        mq_out      <= div_dividend[WORD_W-1:0];
                        link_out    <= 1'b1;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= FLUSH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eae_div_sequencer.sv
// Self-checking bench for eae_div_sequencer: a divider model driven from the
// DUT's start strobe, a per-cycle reference model built from operation
// latencies and plain arithmetic, directed literal cases and random traffic.
module tb_eae_div_sequencer;

    localparam int TIMEOUT = 32;
    localparam int FLUSH   = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [11:0] ac_in = '0, mq_in = '0, divisor_in = '0;
    logic        busy, done, link_out, timeout_err, div_start;
    logic [11:0] ac_out, mq_out, div_divisor;
    logic [23:0] div_dividend;
    logic [11:0] div_quotient = '0, div_remainder = '0;
    logic        div_finished = 1'b0;
    eae_pkg::div_seq_state_t fsm_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic stub_dead = 1'b0;
    logic spurious_en = 1'b0;

    eae_div_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .FLUSH_CYCLES(FLUSH)) dut (
        .clock(clock), .reset_n(reset_n), .req(req),
        .ac_in(ac_in), .mq_in(mq_in), .divisor_in(divisor_in),
        .busy(busy), .done(done), .ac_out(ac_out), .mq_out(mq_out),
        .link_out(link_out), .timeout_err(timeout_err),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_finished(div_finished), .fsm_state(fsm_state)
    );

    // ---------------- clock / cycle index ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- divider model ----------------
    // Start seen in cycle c1 -> finished pulse in c14 with the divide result.
    initial begin : divider
        int dl;
        logic st, rs, sd;
        logic [23:0] dd, tmp;
        logic [11:0] ds, dq, dr;
        dl = 0; dq = '0; dr = '0;
        forever begin
            @(negedge clock);
            st = div_start; rs = reset_n; sd = stub_dead;
            dd = div_dividend; ds = div_divisor;
            @(posedge clock);
            #1;
            if (!rs) dl = 0;
            else if (st && !sd) begin
                dl = 13;
                tmp = dd / {12'd0, ds}; dq = tmp[11:0];
                tmp = dd % {12'd0, ds}; dr = tmp[11:0];
            end else if (dl > 0) dl--;
            div_finished = (dl == 1) ||
                           (spurious_en && !sd && dl == 0 && $urandom_range(0, 5) == 0);
            div_quotient  = (dl == 1) ? dq : 12'($urandom);
            div_remainder = (dl == 1) ? dr : 12'($urandom);
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    initial begin : compare
        bit in_rst, e_busy, e_done, e_start;
        int busy_until, launch_at, done_at;
        logic [11:0] r_ac, r_mq, h_ac, h_mq, h_dvs;
        logic r_link, r_te, h_link, h_te;
        logic [23:0] h_dvd, q24;
        in_rst = 1; busy_until = 0; launch_at = -1; done_at = -1;
        r_ac = '0; r_mq = '0; r_link = 0; r_te = 0;
        h_ac = '0; h_mq = '0; h_link = 0; h_te = 0; h_dvd = '0; h_dvs = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                in_rst = 1; launch_at = -1; done_at = -1;
                h_ac = '0; h_mq = '0; h_link = 0; h_te = 0; h_dvd = '0; h_dvs = '0;
                e_busy = 1; e_done = 0; e_start = 0;
            end else begin
                if (in_rst) begin
                    in_rst = 0;
                    busy_until = cyc + FLUSH - 1;
                end
                e_busy  = (cyc <= busy_until);
                e_done  = (cyc == done_at);
                e_start = (cyc == launch_at);
                if (e_done) begin
                    h_ac = r_ac; h_mq = r_mq; h_link = r_link; h_te = r_te;
                end
            end
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("div_start", div_start, e_start);
            check("ac_out", ac_out, h_ac);
            check("mq_out", mq_out, h_mq);
            check("link_out", link_out, h_link);
            check("timeout_err", timeout_err, h_te);
            check("div_dividend", div_dividend, h_dvd);
            check("div_divisor", div_divisor, h_dvs);
            if (reset_n && !e_busy && req) begin
                h_te = 0; h_dvd = {ac_in, mq_in}; h_dvs = divisor_in;
                if (ac_in >= divisor_in) begin
                    launch_at = -1; done_at = cyc + 1;
                    r_ac = ac_in; r_mq = mq_in; r_link = 1; r_te = 0;
                end else if (stub_dead) begin
                    launch_at = cyc + 1; done_at = cyc + TIMEOUT + 2;
                    r_ac = ac_in; r_mq = mq_in; r_link = 1; r_te = 1;
                end else begin
                    launch_at = cyc + 1; done_at = cyc + 15;
                    q24 = {ac_in, mq_in} / {12'd0, divisor_in}; r_mq = q24[11:0];
                    q24 = {ac_in, mq_in} % {12'd0, divisor_in}; r_ac = q24[11:0];
                    r_link = 0; r_te = 0;
                end
                busy_until = done_at;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (n < 200) begin
            @(negedge clock);
            if (!busy) break;
            n++;
        end
        check("idle_wait", n < 200, 1);
    endtask

    task automatic do_op(input string tag, input logic [11:0] a, input logic [11:0] m,
                         input logic [11:0] d, input int exp_lat,
                         input logic [11:0] ea, input logic [11:0] em,
                         input logic el, input logic et);
        int c0, n_start, n;
        bit got;
        n_start = 0; got = 0;
        wait_idle();
        @(posedge clock); #1;
        ac_in = a; mq_in = m; divisor_in = d; req = 1'b1; c0 = cyc;
        @(posedge clock); #1;
        req = 1'b0;
        for (n = 0; n < 60; n++) begin
            @(negedge clock);
            if (div_start) n_start++;
            if (done) begin got = 1; break; end
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_latency"}, cyc - c0, exp_lat);
        check({tag, "_mq"}, mq_out, em);
        check({tag, "_ac"}, ac_out, ea);
        check({tag, "_link"}, link_out, el);
        check({tag, "_timeout"}, timeout_err, et);
        check({tag, "_starts"}, n_start, (exp_lat == 1) ? 0 : 1);
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clock); #1;
        reset_n = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int c0, nb, n, d_cnt;
        int d_at[3];
        bit ovf;

        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Flush window: busy for exactly 16 cycles after release.
        nb = 0;
        for (n = 0; n < 40; n++) begin
            @(negedge clock);
            if (!busy) break;
            nb++;
        end
        check("flush_busy_len", nb, 16);

        do_op("t1", 12'd0, 12'd100, 12'd7, 15, 12'd2, 12'd14, 1'b0, 1'b0);
        do_op("t2", 12'h7FF, 12'hFFF, 12'hFFF, 15, 12'h7FF, 12'h800, 1'b0, 1'b0);
        do_op("t3a", 12'd5, 12'h123, 12'd5, 1, 12'd5, 12'h123, 1'b1, 1'b0);
        do_op("t3b", 12'd5, 12'h456, 12'd0, 1, 12'd5, 12'h456, 1'b1, 1'b0);

        // Dead divider: timeout path, then a good op clears the error.
        wait_idle();
        stub_dead = 1'b1;
        do_op("t4", 12'd1, 12'd2, 12'd3, TIMEOUT + 2, 12'd1, 12'd2, 1'b1, 1'b1);
        stub_dead = 1'b0;
        do_op("t4_clr", 12'd0, 12'd100, 12'd7, 15, 12'd2, 12'd14, 1'b0, 1'b0);

        // Reset during WAIT: no done, flush again, then a clean repeat.
        wait_idle();
        @(posedge clock); #1;
        ac_in = 12'd0; mq_in = 12'd100; divisor_in = 12'd7; req = 1'b1; c0 = cyc;
        @(posedge clock); #1;
        req = 1'b0;
        while (cyc < c0 + 7) begin @(posedge clock); #1; end
        pulse_reset(2);
        nb = 0;
        for (n = 0; n < 40; n++) begin
            @(negedge clock);
            if (!busy) break;
            nb++;
        end
        check("t5_flush_busy_len", nb, 16);
        check("t5_ac_cleared", ac_out, 12'd0);
        do_op("t5_redo", 12'd0, 12'd100, 12'd7, 15, 12'd2, 12'd14, 1'b0, 1'b0);

        // req held high: three back-to-back ops, 16 cycles apart.
        wait_idle();
        @(posedge clock); #1;
        ac_in = 12'd0; mq_in = 12'd100; divisor_in = 12'd7; req = 1'b1; c0 = cyc;
        d_cnt = 0;
        for (n = 0; n < 80 && d_cnt < 3; n++) begin
            @(negedge clock);
            if (done) begin d_at[d_cnt] = cyc; d_cnt++; end
        end
        @(posedge clock); #1;
        req = 1'b0;
        check("t6_done_count", d_cnt, 3);
        if (d_cnt == 3) begin
            check("t6_first", d_at[0] - c0, 15);
            check("t6_gap1", d_at[1] - d_at[0], 16);
            check("t6_gap2", d_at[2] - d_at[1], 16);
        end

        // Random traffic with spurious finished pulses outside WAIT.
        spurious_en = 1'b1;
        for (n = 0; n < 2500; n++) begin
            @(posedge clock); #1;
            req = ($urandom_range(0, 3) == 0);
            divisor_in = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 20)) : 12'($urandom);
            ovf = ($urandom_range(0, 4) == 0) || (divisor_in == 12'd0);
            if (ovf) ac_in = 12'($urandom_range(int'(divisor_in), 4095));
            else     ac_in = 12'($urandom_range(0, int'(divisor_in) - 1));
            mq_in = 12'($urandom);
        end
        req = 1'b0;
        spurious_en = 1'b0;
        wait_idle();
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
